// File: rtl/pipe_stage_if.sv
// Handshake and payload bundle between an upstream producer, the pipeline
// register stage and its downstream consumer.
interface pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int SEL_W  = 5,
  parameter int OP_W   = 3
);
  // upstream side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rd1;
  logic [DATA_W-1:0] in_rd2;
  logic [IMM_W-1:0]  in_imm;
  logic              in_datasrc;
  logic [OP_W-1:0]   in_aluop;
  logic [SEL_W-1:0]  in_wsel;
  logic              in_we;

  // downstream side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rd1;
  logic [DATA_W-1:0] out_rd2;
  logic [DATA_W-1:0] out_imm_ext;
  logic              out_datasrc;
  logic [OP_W-1:0]   out_aluop;
  logic [SEL_W-1:0]  out_wsel;
  logic              out_we;

  // producer/consumer environment around the stage
  modport master (
    output in_valid, in_rd1, in_rd2, in_imm, in_datasrc, in_aluop, in_wsel, in_we,
    input  in_ready,
    input  out_valid, out_rd1, out_rd2, out_imm_ext, out_datasrc, out_aluop,
           out_wsel, out_we,
    output out_ready
  );

  // the pipeline stage itself
  modport slave (
    input  in_valid, in_rd1, in_rd2, in_imm, in_datasrc, in_aluop, in_wsel, in_we,
    output in_ready,
    output out_valid, out_rd1, out_rd2, out_imm_ext, out_datasrc, out_aluop,
           out_wsel, out_we,
    input  out_ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register between decode and execute.
// The main register drives the outputs; the skid register absorbs the one
// entry that may arrive in the cycle downstream stops accepting, so in_ready
// can be a plain register with no combinational path from out_ready.
//
// state | meaning
// EMPTY | no entry held, out_valid=0, in_ready=1
// ONE   | main holds an entry, skid unused, in_ready=1
// FULL  | main and skid both hold entries, in_ready=0
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int SEL_W  = 5,
  parameter int OP_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  pipe_stage_if.slave bus,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm_ext;
    logic              datasrc;
    logic [OP_W-1:0]   aluop;
    logic [SEL_W-1:0]  wsel;
    logic              we;
  } entry_t;

  state_t            state;
  entry_t            main_q;
  entry_t            skid_q;
  entry_t            in_entry;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] imm_ext;

  // The immediate is widened once, at capture, so the held entry is already
  // in execute-stage form.
  generate
    if (IMM_W == DATA_W) begin : g_imm_pass
      assign imm_ext = bus.in_imm;
    end else begin : g_imm_sext
      assign imm_ext = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
    end
  endgenerate

  assign in_entry = '{
    rd1:     bus.in_rd1,
    rd2:     bus.in_rd2,
    imm_ext: imm_ext,
    datasrc: bus.in_datasrc,
    aluop:   bus.in_aluop,
    wsel:    bus.in_wsel,
    we:      bus.in_we
  };

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Occupancy FSM: moves entries between input, skid and main, and registers
  // the handshake outputs alongside the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Payload bits are left as they are; only the write enables are
      // dropped so a flushed entry can never commit a register write.
      state       <= EMPTY;
      main_q.we   <= 1'b0;
      skid_q.we   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= in_entry;
            state       <= ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q      <= in_entry;
            state       <= ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end else if (in_fire) begin
            skid_q      <= in_entry;
            state       <= FULL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (out_fire) begin
            // Going empty: the stale main entry must not look like a write.
            main_q.we   <= 1'b0;
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            main_q      <= skid_q;
            state       <= ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          main_q.we   <= 1'b0;
          skid_q.we   <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of backpressure cycles; only a reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (out_valid_q && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd1     = main_q.rd1;
  assign bus.out_rd2     = main_q.rd2;
  assign bus.out_imm_ext = main_q.imm_ext;
  assign bus.out_datasrc = main_q.datasrc;
  assign bus.out_aluop   = main_q.aluop;
  assign bus.out_wsel    = main_q.wsel;
  assign bus.out_we      = main_q.we;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue-based model of the stage (at most two
// entries in flight, in order) plus directed scenarios with literal values.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int SEL_W  = 5;
  localparam int OP_W   = 3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] stall_cnt;

  pipe_stage_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SEL_W(SEL_W), .OP_W(OP_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SEL_W(SEL_W), .OP_W(OP_W)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        ds;
    logic [2:0]  op;
    logic [4:0]  ws;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_stall;
  int          total;
  int          bad;

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [15:0] imm, input logic ds, input logic [2:0] op,
                       input logic [4:0] ws, input logic we);
    bus.in_valid   = v;
    bus.in_rd1     = rd1;
    bus.in_rd2     = rd2;
    bus.in_imm     = imm;
    bus.in_datasrc = ds;
    bus.in_aluop   = op;
    bus.in_wsel    = ws;
    bus.in_we      = we;
  endtask

  // Compare every DUT output against the model's view of the stage.
  task automatic compare();
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() < 2));
    chk("out_we",    64'(bus.out_we),    64'((mq.size() > 0) ? mq[0].we : 1'b0));
    chk("stall_cnt", 64'(stall_cnt),     64'(m_stall));
    if (mq.size() > 0) begin
      chk("out_rd1",     64'(bus.out_rd1),     64'(mq[0].rd1));
      chk("out_rd2",     64'(bus.out_rd2),     64'(mq[0].rd2));
      chk("out_imm_ext", 64'(bus.out_imm_ext), 64'(mq[0].imm));
      chk("out_datasrc", 64'(bus.out_datasrc), 64'(mq[0].ds));
      chk("out_aluop",   64'(bus.out_aluop),   64'(mq[0].op));
      chk("out_wsel",    64'(bus.out_wsel),    64'(mq[0].ws));
    end
  endtask

  // Advance the model by the edge about to happen, take the edge, then check.
  task automatic step();
    bit   can_in;
    bit   has_out;
    ent_t e;
    can_in  = (mq.size() < 2);
    has_out = (mq.size() > 0);
    if (has_out && !bus.out_ready && m_stall != 16'hFFFF) m_stall++;
    if (flush) begin
      mq.delete();
    end else begin
      if (has_out && bus.out_ready) void'(mq.pop_front());
      if (bus.in_valid && can_in) begin
        e.rd1 = bus.in_rd1;
        e.rd2 = bus.in_rd2;
        e.imm = sext(bus.in_imm);
        e.ds  = bus.in_datasrc;
        e.op  = bus.in_aluop;
        e.ws  = bus.in_wsel;
        e.we  = bus.in_we;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_stall = 16'd0;
    rst     = 1'b1;
    flush   = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_rd1",   64'(bus.out_rd1),   64'd0);
    chk("rst_out_we",    64'(bus.out_we),    64'd0);
    chk("rst_stall",     64'(stall_cnt),     64'd0);
    rst = 1'b0;

    // first transfer right after reset, with a negative immediate
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h1234, 32'h55, 16'h8001, 1'b1, 3'd2, 5'd7, 1'b1);
    step();
    chk("first_valid", 64'(bus.out_valid),   64'd1);
    chk("first_rd1",   64'(bus.out_rd1),     64'h1234);
    chk("first_imm",   64'(bus.out_imm_ext), 64'hFFFF8001);

    // back-to-back stream at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 32'(i), 16'(16'h7FF0 + i), i[0], 3'(i), 5'(i), 1'b1);
      step();
      chk("stream_rd1",   64'(bus.out_rd1),  64'(32'hA0 + 32'(i)));
      chk("stream_ready", 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    step();
    chk("stream_drain", 64'(bus.out_valid), 64'd0);

    // backpressure: A on output, B in skid, C held upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'd1, 16'h0001, 1'b0, 3'd1, 5'd1, 1'b1);
    step();
    drive(1'b1, 32'hB, 32'd2, 16'h0002, 1'b0, 3'd1, 5'd2, 1'b1);
    step();
    chk("bp_a_main", 64'(bus.out_rd1),  64'hA);
    chk("bp_full",   64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'hC, 32'd3, 16'h0003, 1'b0, 3'd1, 5'd3, 1'b1);
    step();
    chk("bp_a_held", 64'(bus.out_rd1), 64'hA);
    bus.out_ready = 1'b1;
    step();
    chk("bp_b_out", 64'(bus.out_rd1), 64'hB);
    step();
    chk("bp_c_out", 64'(bus.out_rd1), 64'hC);
    drive(1'b0, 32'd0, 32'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    step();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // flush from FULL, discarding a same-cycle input
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hD1, 32'd0, 16'h0011, 1'b1, 3'd3, 5'd9, 1'b1);
    step();
    drive(1'b1, 32'hD2, 32'd0, 16'h0012, 1'b1, 3'd3, 5'd10, 1'b1);
    step();
    chk("fl_pre_we", 64'(bus.out_we), 64'd1);
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 32'd0, 16'h0013, 1'b1, 3'd3, 5'd11, 1'b1);
    step();
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_we",    64'(bus.out_we),    64'd0);
    chk("fl_ready", 64'(bus.in_ready),  64'd1);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    repeat (3) step();

    // randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, $urandom, 16'($urandom),
            1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;

    // asynchronous reset between edges while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hE1, 32'd0, 16'h0021, 1'b0, 3'd0, 5'd1, 1'b1);
    step();
    step();
    chk("ar_full", 64'(bus.in_ready), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_ready", 64'(bus.in_ready),  64'd1);
    chk("ar_we",    64'(bus.out_we),    64'd0);
    mq.delete();
    m_stall = 16'd0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hF00D, 32'd4, 16'h0004, 1'b0, 3'd0, 5'd2, 1'b0);
    step();
    chk("ar_first_valid", 64'(bus.out_valid), 64'd1);
    chk("ar_first_rd1",   64'(bus.out_rd1),   64'hF00D);

    // long stall: counter saturates, survives flush, clears on reset
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 16'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    for (int i = 0; i < 70000; i++) step();
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_flush", 64'(stall_cnt), 64'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("stall_rst", 64'(stall_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of both register read-data operands.
REQ-002 The block SHALL have parameter IMM_W, default 16, raw immediate width; the constraint IMM_W <= DATA_W SHALL hold.
REQ-003 The block SHALL have parameter SEL_W, default 5, write-select width.
REQ-004 The block SHALL have parameter OP_W, default 3, ALU-op width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream holds a valid instruction.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the stage can accept an instruction.
REQ-010 The block SHALL have ports in_rd1 and in_rd2, input, DATA_W each: operands.
REQ-011 The block SHALL have ports in_imm (input, IMM_W), in_datasrc (input, 1), in_aluop (input, OP_W), in_wsel (input, SEL_W) and in_we (input, 1): the control payload.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the output payload is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-014 The block SHALL have ports out_rd1, out_rd2, out_imm_ext (all DATA_W), out_datasrc, out_aluop, out_wsel and out_we, all outputs: the registered payload.
REQ-015 The block SHALL have port stall_cnt, output, 16 bits: backpressure-cycle counter.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 The block SHALL be a 2-entry skid buffer: a main register drives the outputs, and a skid register captures one extra entry.
REQ-018 The state SHALL be one of EMPTY, ONE or FULL, encoded as 0, 1 or 2 entries held.
REQ-019 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-020 In EMPTY, an input transfer SHALL load main and go to ONE.
REQ-021 In ONE, the transitions SHALL be:
- input only -> load skid, go to FULL;
- output only -> go to EMPTY;
- input and output together -> load main, stay in ONE.
REQ-022 In FULL, an output transfer SHALL move skid to main and go to ONE; with no output transfer, FULL SHALL hold.
REQ-023 out_valid SHALL be 1 exactly when state != EMPTY.
REQ-024 Latency SHALL be 1 cycle from an input transfer into EMPTY to out_valid=1.
REQ-025 Throughput SHALL be 1 transfer per cycle while out_ready=1.
REQ-026 Order SHALL be preserved, with no duplication or loss outside a flush.
REQ-027 out_imm_ext SHALL be in_imm sign-extended from IMM_W to DATA_W, computed at capture.
REQ-028 When IMM_W == DATA_W, out_imm_ext SHALL pass in_imm through unchanged.
REQ-029 Payload outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 flush=1 SHALL take priority over all transfers at the clock edge:
- state goes to EMPTY;
- any same-cycle input transfer is discarded;
- main and skid out_we copies are cleared to 0;
- other payload bits keep their values.
REQ-031 While state = EMPTY, out_we SHALL read 0, so a bubble never writes.
REQ-032 stall_cnt SHALL increment on each cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF and clearing only on rst.
REQ-033 stall_cnt SHALL NOT be cleared by flush.

Reset
REQ-034 While rst=1, independent of clk:
- state = EMPTY, in_ready = 1, out_valid = 0;
- all payload outputs and the skid register = 0;
- stall_cnt = 0.
REQ-035 Reset asserted mid-transfer SHALL discard all held entries.
REQ-036 The first input transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-037 The bench SHALL cover: reset, then in_valid=1 with rd1=32'h1234, imm=16'h8001, out_ready=1 -> next cycle out_valid=1, out_rd1=32'h1234, out_imm_ext=32'hFFFF8001.
REQ-038 The bench SHALL cover: a stream of 8 entries A0..A7 with out_ready=1 -> outputs A0..A7 on consecutive cycles, in_ready stays 1.
REQ-039 The bench SHALL cover: out_ready=0 while feeding A, B, C -> A on the outputs, B in skid, in_ready=0, C held upstream; then out_ready=1 -> outputs A, B, C in order, none lost.
REQ-040 The bench SHALL cover: FULL with out_we=1, then flush=1 together with in_valid=1 -> next cycle out_valid=0, out_we=0, in_ready=1, and the flushed input never appears.
REQ-041 The bench SHALL cover: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; then flush -> stall_cnt unchanged; then rst -> stall_cnt=0.
REQ-042 The bench SHALL cover: rst asserted asynchronously between clock edges while FULL -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
